rs_latch_monitor: RTL

- Clocked observer at the far end of the R/S latch interface: samples R, S, Q, Q_L and classifies each drive mode (RESET/HOLD/SET/INVALID).
- Tracks the expected latch state and flags any output that disagrees with the NOR-latch model.
- Counts mode entries; it is the self-checking companion to stimulus-driven latch benches and board-level latch probes.
- Inputs are asynchronous to CLK, so they are synchronized internally.

---
 rtl/rs_latch_pkg.sv | 25 ++
 rtl/rs_latch_monitor_sync2.sv | 23 ++
 rtl/rs_latch_monitor.sv | 117 +++++++++++
 3 files changed

// File: rtl/rs_latch_pkg.sv
// Shared encodings and expected-output lookup for the R/S latch monitor.
package rs_latch_pkg;

   localparam logic [1:0] MODE_HOLD    = 2'b00;
   localparam logic [1:0] MODE_SET     = 2'b01;
   localparam logic [1:0] MODE_RESET   = 2'b10;
   localparam logic [1:0] MODE_INVALID = 2'b11;

   typedef enum logic [1:0] {
      ST_UNK   = 2'd0,
      ST_ZERO  = 2'd1,
      ST_ONE   = 2'd2,
      ST_BOTH0 = 2'd3
   } state_t;

   // Expected {Q,Q_L} for a known latch state; UNK is handled separately by the checker.
   function automatic logic [1:0] exp_out(input state_t st);
      case (st)
         ST_ZERO: return 2'b01;
         ST_ONE:  return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/rs_latch_monitor_sync2.sv
// Two-flop synchronizer with synchronous active-low clear.
module sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rs_latch_monitor.sv
// Clocked observer of an R/S NOR latch: classifies drive mode, tracks the
// expected latch state and flags outputs that disagree with it.
module rs_latch_monitor
   import rs_latch_pkg::*;
#(
   parameter int unsigned SETTLE = 4,
   parameter int unsigned CW     = 8
) (
   input  logic          CLK,
   input  logic          RESET_L,
   input  logic          R,
   input  logic          S,
   input  logic          Q,
   input  logic          Q_L,
   output logic [1:0]    MODE,
   output logic          EXP_VALID,
   output logic          EXP_Q,
   output logic          ERR_PULSE,
   output logic          ERR,
   output logic [CW-1:0] SET_CNT,
   output logic [CW-1:0] RST_CNT,
   output logic [CW-1:0] INV_CNT,
   output logic [CW-1:0] ERR_CNT
);

   localparam int unsigned    SW      = $clog2(SETTLE + 1);
   localparam logic [CW-1:0]  CNT_MAX = '1;

   logic [3:0]    synced;
   logic [1:0]    rs_s;
   logic          q_s;
   logic          ql_s;
   logic          mode_chg;
   logic          mismatch;
   logic [SW-1:0] settle;
   state_t        state;
   state_t        state_nxt;

   sync2 #(.WIDTH(4)) u_sync (
      .clk   (CLK),
      .rst_n (RESET_L),
      .d     ({R, S, Q, Q_L}),
      .q     (synced)
   );

   assign rs_s     = synced[3:2];
   assign q_s      = synced[1];
   assign ql_s     = synced[0];
   assign mode_chg = (rs_s != MODE);

   always_ff @(posedge CLK) begin
      if (!RESET_L) state <= ST_UNK;
      else          state <= state_nxt;
   end

   // A mode change always takes priority over UNK adoption.
   always_comb begin
      state_nxt = state;
      if (mode_chg) begin
         case (rs_s)
            MODE_RESET:   state_nxt = ST_ZERO;
            MODE_SET:     state_nxt = ST_ONE;
            MODE_INVALID: state_nxt = ST_BOTH0;
            MODE_HOLD:    if (state == ST_BOTH0) state_nxt = ST_UNK;
            default:      state_nxt = state;
         endcase
      end else if (state == ST_UNK && MODE == MODE_HOLD && settle == '0 && q_s != ql_s) begin
         state_nxt = q_s ? ST_ONE : ST_ZERO;
      end
   end

   always_comb begin
      EXP_VALID = (state != ST_UNK);
      EXP_Q     = (state == ST_ONE);
   end

   always_comb begin
      mismatch = 1'b0;
      if (!mode_chg && settle == '0) begin
         if (state == ST_UNK) mismatch = (q_s == ql_s);
         else                 mismatch = ({q_s, ql_s} != exp_out(state));
      end
   end

   // Mode register, settle window, error flags and saturating counters.
   always_ff @(posedge CLK) begin
      if (!RESET_L) begin
         MODE      <= MODE_HOLD;
         settle    <= SW'(SETTLE);
         ERR_PULSE <= 1'b0;
         ERR       <= 1'b0;
         SET_CNT   <= '0;
         RST_CNT   <= '0;
         INV_CNT   <= '0;
         ERR_CNT   <= '0;
      end else begin
         ERR_PULSE <= mismatch;
         if (mismatch) begin
            ERR <= 1'b1;
            if (ERR_CNT != CNT_MAX) ERR_CNT <= ERR_CNT + CW'(1);
         end
         if (mode_chg) begin
            MODE   <= rs_s;
            settle <= SW'(SETTLE);
            case (rs_s)
               MODE_SET:     if (SET_CNT != CNT_MAX) SET_CNT <= SET_CNT + CW'(1);
               MODE_RESET:   if (RST_CNT != CNT_MAX) RST_CNT <= RST_CNT + CW'(1);
               MODE_INVALID: if (INV_CNT != CNT_MAX) INV_CNT <= INV_CNT + CW'(1);
               default:      ;
            endcase
         end else if (settle != '0) begin
            settle <= settle - SW'(1);
         end
      end
   end

endmodule
